// File: rtl/ntt_op_sequencer.sv
// Host-side command sequencer for the NTT1024 core: steps the core through one
// full polynomial multiply per start pulse, feeding operand words from a valid/ready source.
module ntt_op_sequencer #(
  parameter int unsigned W_LEN    = 1760,
  parameter int unsigned WAIT_CYC = 126,
  parameter int unsigned RD_CYC   = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        reuse_w,
  input  logic [3:0]  ring_depth,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic [4:0]  op_code,
  output logic        din_valid,
  output logic [31:0] din0,
  output logic        busy,
  output logic        done,
  output logic [3:0]  phase
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_OPC  = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_READ = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam logic [3:0] P_IDLE  = 4'd0;
  localparam logic [3:0] P_PARAM = 4'd1;
  localparam logic [3:0] P_W     = 4'd2;
  localparam logic [3:0] P_DATA  = 4'd3;
  localparam logic [3:0] P_NTT   = 4'd4;
  localparam logic [3:0] P_PWM   = 4'd5;
  localparam logic [3:0] P_READ0 = 4'd6;
  localparam logic [3:0] P_WINV  = 4'd7;
  localparam logic [3:0] P_INTT  = 4'd8;
  localparam logic [3:0] P_READ1 = 4'd9;

  localparam logic [11:0] W_LAST    = 12'(W_LEN - 1);
  localparam logic [11:0] WAIT_LAST = 12'(WAIT_CYC - 1);
  localparam logic [11:0] RD_LAST   = 12'(RD_CYC - 1);

  function automatic logic [4:0] opcode_of(input logic [3:0] p);
    case (p)
      P_PARAM: opcode_of = 5'b00001;
      P_W:     opcode_of = 5'b00010;
      P_DATA:  opcode_of = 5'b00011;
      P_NTT:   opcode_of = 5'b00100;
      P_PWM:   opcode_of = 5'b01010;
      P_READ0: opcode_of = 5'b01011;
      P_WINV:  opcode_of = 5'b00010;
      P_INTT:  opcode_of = 5'b00111;
      P_READ1: opcode_of = 5'b01000;
      default: opcode_of = 5'b00000;
    endcase
  endfunction

  function automatic logic [3:0] next_of(input logic [3:0] p);
    case (p)
      P_PARAM: next_of = P_W;
      P_W:     next_of = P_DATA;
      P_DATA:  next_of = P_NTT;
      P_NTT:   next_of = P_PWM;
      P_PWM:   next_of = P_READ0;
      P_READ0: next_of = P_WINV;
      P_WINV:  next_of = P_INTT;
      P_INTT:  next_of = P_READ1;
      default: next_of = P_IDLE;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] p);
    is_load = (p == P_PARAM) || (p == P_W) || (p == P_DATA) || (p == P_WINV);
  endfunction

  function automatic logic is_read(input logic [3:0] p);
    is_read = (p == P_READ0) || (p == P_READ1);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [11:0] cnt_q, cnt_d;
  logic        big_q, big_d;
  logic        src_ready_q, src_ready_d;
  logic [4:0]  op_code_q, op_code_d;
  logic        din_valid_q, din_valid_d;
  logic [31:0] din0_q, din0_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;
  logic [11:0] load_last;

  always_comb begin
    case (phase_q)
      P_PARAM: load_last = 12'd2;
      P_DATA:  load_last = big_q ? 12'd2047 : 12'd1023;
      default: load_last = W_LAST;
    endcase
  end

  assign accept = (state_q == S_LOAD) && src_valid;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    big_d   = big_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          big_d   = (ring_depth == 4'd10);
          phase_d = reuse_w ? P_DATA : P_PARAM;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_OPC;
      S_OPC: begin
        cnt_d = '0;
        if (is_load(phase_q))      state_d = S_LOAD;
        else if (is_read(phase_q)) state_d = S_READ;
        else                       state_d = S_WAIT;
      end
      S_LOAD: begin
        if (src_valid) begin
          if (cnt_q == load_last) begin
            cnt_d   = '0;
            phase_d = next_of(phase_q);
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          phase_d = next_of(phase_q);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          cnt_d = '0;
          if (phase_q == P_READ1) begin
            state_d = S_FIN;
          end else begin
            phase_d = next_of(phase_q);
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_FIN: begin
        phase_d = P_IDLE;
        state_d = S_IDLE;
      end
      default: begin
        phase_d = P_IDLE;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state; load data lags its handshake by one cycle.
  always_comb begin
    src_ready_d = (state_d == S_LOAD);
    op_code_d   = (state_d == S_OPC) ? opcode_of(phase_d) : 5'b00000;
    din_valid_d = accept || ((state_d == S_OPC) && is_read(phase_d)) || (state_d == S_READ);
    din0_d      = accept ? src_data : '0;
    busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d      = (state_d == S_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= P_IDLE;
      cnt_q       <= '0;
      big_q       <= 1'b0;
      src_ready_q <= 1'b0;
      op_code_q   <= '0;
      din_valid_q <= 1'b0;
      din0_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      big_q       <= big_d;
      src_ready_q <= src_ready_d;
      op_code_q   <= op_code_d;
      din_valid_q <= din_valid_d;
      din0_q      <= din0_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign src_ready = src_ready_q;
  assign op_code   = op_code_q;
  assign din_valid = din_valid_q;
  assign din0      = din0_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_ntt_op_sequencer.sv
// Scoreboard bench for ntt_op_sequencer: stimulus and source push expectations,
// a monitor pops and compares opcode pulses, delivered words and per-run totals.
module tb_ntt_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        reuse_w = 1'b0;
  logic [3:0]  ring_depth = 4'd9;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_ready;
  logic [4:0]  op_code;
  logic        din_valid;
  logic [31:0] din0;
  logic        busy;
  logic        done;
  logic [3:0]  phase;

  always #5 clk = ~clk;

  ntt_op_sequencer #(
    .W_LEN    (1760),
    .WAIT_CYC (126),
    .RD_CYC   (26)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .reuse_w    (reuse_w),
    .ring_depth (ring_depth),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .op_code    (op_code),
    .din_valid  (din_valid),
    .din0       (din0),
    .busy       (busy),
    .done       (done),
    .phase      (phase)
  );

  typedef struct {
    int unsigned wp;
    int unsigned ww;
    int unsigned wd;
    int unsigned wi;
    int          busy;
  } run_t;

  logic [8:0]  exp_op[$];
  logic [31:0] exp_word[$];
  run_t        exp_run[$];

  // source-owned
  int unsigned acc[16];
  int unsigned src_k = 0;
  // stimulus-owned
  int unsigned src_en = 0;
  int unsigned stall_pct = 0;
  int unsigned timeout_cnt = 0;
  int unsigned snap_seq = 0;
  logic [44:0] snap = '0;
  bit          tb_done = 1'b0;
  // monitor-owned
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned done_cnt = 0;
  int unsigned base[16];
  int unsigned busy_cyc = 0;
  int unsigned rd_cnt = 0;
  int unsigned snap_seen = 0;
  run_t        r;

  function automatic logic [31:0] gen(input int unsigned k);
    gen = (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 20) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    if (failures <= 20) $display("FAIL %s actual=present required=absent", name);
  endtask

  // Source: drives words on the falling edge, records handshakes just before the rising edge.
  initial begin
    for (int i = 0; i < 16; i++) acc[i] = 0;
    forever begin
      @(negedge clk);
      src_data  = gen(src_k);
      src_valid = (src_en != 0) && ($urandom_range(99) >= stall_pct);
      #4;
      if (src_valid && src_ready && !reset) begin
        exp_word.push_back(src_data);
        acc[phase] = acc[phase] + 1;
        src_k++;
      end
    end
  end

  // Monitor
  initial begin
    for (int i = 0; i < 16; i++) base[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (snap_seq != snap_seen) begin
        snap_seen = snap_seq;
        chk("reset_outputs", 64'(snap), 64'd0);
      end
      if (reset) begin
        exp_op.delete();
        exp_word.delete();
        exp_run.delete();
        for (int i = 0; i < 16; i++) base[i] = acc[i];
        busy_cyc = 0;
        rd_cnt   = 0;
      end else begin
        if (op_code != 5'd0) begin
          chk("opc_src_ready", 64'(src_ready), 64'd0);
          if (exp_op.size() == 0) fail_now("op_extra");
          else chk("op_seq", 64'({phase, op_code}), 64'(exp_op.pop_front()));
        end
        if (din_valid) begin
          if (phase == 4'd6 || phase == 4'd9) begin
            rd_cnt++;
            chk("rd_din0", 64'(din0), 64'd0);
          end else if (exp_word.size() == 0) begin
            fail_now("word_extra");
          end else begin
            chk("din0_word", 64'(din0), 64'(exp_word.pop_front()));
          end
        end
        if (busy) busy_cyc++;
        if (done) begin
          done_cnt++;
          chk("done_busy", 64'(busy), 64'd0);
          if (exp_run.size() == 0) begin
            fail_now("done_extra");
          end else begin
            r = exp_run.pop_front();
            chk("words_param", 64'(acc[1] - base[1]), 64'(r.wp));
            chk("words_w",     64'(acc[2] - base[2]), 64'(r.ww));
            chk("words_data",  64'(acc[3] - base[3]), 64'(r.wd));
            chk("words_winv",  64'(acc[7] - base[7]), 64'(r.wi));
            chk("read_cycles", 64'(rd_cnt), 64'd54);
            if (r.busy >= 0) chk("busy_cycles", 64'(busy_cyc), 64'(r.busy));
            chk("ops_left",   64'(exp_op.size()), 64'd0);
            chk("words_left", 64'(exp_word.size()), 64'd0);
          end
          for (int i = 0; i < 16; i++) base[i] = acc[i];
          busy_cyc = 0;
          rd_cnt   = 0;
        end
        if (tb_done) begin
          chk("runs_left",  64'(exp_run.size()), 64'd0);
          chk("timeouts",   64'(timeout_cnt), 64'd0);
          chk("done_total", 64'(done_cnt), 64'd5);
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $finish;
        end
      end
    end
  end

  task automatic take_snapshot();
    snap = {op_code, din_valid, din0, src_ready, busy, done, phase};
    snap_seq++;
  endtask

  task automatic push_run(input bit reuse, input int unsigned wp, input int unsigned ww,
                          input int unsigned wd, input int unsigned wi, input int bsy);
    run_t e;
    if (!reuse) begin
      exp_op.push_back({4'd1, 5'h01});
      exp_op.push_back({4'd2, 5'h02});
    end
    exp_op.push_back({4'd3, 5'h03});
    exp_op.push_back({4'd4, 5'h04});
    exp_op.push_back({4'd5, 5'h0A});
    exp_op.push_back({4'd6, 5'h0B});
    exp_op.push_back({4'd7, 5'h02});
    exp_op.push_back({4'd8, 5'h07});
    exp_op.push_back({4'd9, 5'h08});
    e.wp = wp; e.ww = ww; e.wd = wd; e.wi = wi; e.busy = bsy;
    exp_run.push_back(e);
  endtask

  task automatic start_pulse(input bit reuse, input logic [3:0] depth);
    @(negedge clk);
    start = 1'b1; reuse_w = reuse; ring_depth = depth;
    @(negedge clk);
    start = 1'b0; reuse_w = 1'b0; ring_depth = 4'd9;
  endtask

  task automatic wait_done(input int unsigned target);
    for (int i = 0; i < 30000 && done_cnt < target; i++) @(posedge clk);
    if (done_cnt < target) timeout_cnt++;
    repeat (5) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int unsigned b2;
    bit          hit;
    #1 reset = 1'b1;
    #1 take_snapshot();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    src_en = 1;

    // full multiply, n=512, source never stalls
    stall_pct = 0;
    push_run(1'b0, 3, 1760, 1024, 1760, 4995);
    start_pulse(1'b0, 4'd9);
    wait_done(1);

    // n=1024 with 50% source stalls in every load phase
    stall_pct = 50;
    push_run(1'b0, 3, 1760, 2048, 1760, -1);
    start_pulse(1'b0, 4'd10);
    wait_done(2);

    // reuse tables, n=1024, with start pulses while busy
    stall_pct = 0;
    push_run(1'b1, 0, 0, 2048, 1760, 4252);
    start_pulse(1'b1, 4'd10);
    repeat (10) @(negedge clk);
    start_pulse(1'b0, 4'd9);
    repeat (2000) @(negedge clk);
    start_pulse(1'b1, 4'd10);
    wait_done(3);
    repeat (30) @(negedge clk);

    // unsupported ring_depth falls back to n=512
    push_run(1'b1, 0, 0, 1024, 1760, 3228);
    start_pulse(1'b1, 4'd11);
    wait_done(4);

    // reset in the middle of the W load, after 500 words
    push_run(1'b0, 3, 1760, 1024, 1760, 4995);
    b2 = acc[2];
    start_pulse(1'b0, 4'd9);
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      if (acc[2] - b2 >= 500) hit = 1'b1;
    end
    if (!hit) timeout_cnt++;
    reset = 1'b1;
    #1 take_snapshot();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // restart from PARAM after the abort
    push_run(1'b0, 3, 1760, 1024, 1760, 4995);
    start_pulse(1'b0, 4'd9);
    wait_done(5);

    tb_done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_no_finish actual=running required=finished");
    $fatal(1);
  end

endmodule
